// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, run/pause/lap FSM and
// timebase divider driving the BCD counter and display hold register.
module stopwatch_ctrl #(
  parameter int unsigned DIV        = 1200000,
  parameter int unsigned DEB_CYCLES = 65536
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_CLR,
  input  logic       BTN_START,
  input  logic       BTN_STOP,
  input  logic       BTN_LAP,
  output logic       cnt_clr,
  output logic       cnt_inc,
  output logic       lap_load,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
  localparam int unsigned NBTN  = 4;

  // Button indices inside the conditioned vectors
  localparam int unsigned B_CLR   = 0;
  localparam int unsigned B_START = 1;
  localparam int unsigned B_STOP  = 2;
  localparam int unsigned B_LAP   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t             st;
  logic [DIV_W-1:0]   div_cnt;
  logic [NBTN-1:0]    btn_raw;
  logic [NBTN-1:0]    sync1;
  logic [NBTN-1:0]    sync2;
  logic [NBTN-1:0]    stable;
  logic [NBTN-1:0]    ev;
  logic [DEB_W-1:0]   deb_cnt [NBTN];
  logic               ev_clr;
  logic               ev_stop;
  logic               ev_start;
  logic               ev_lap;

  assign btn_raw = {BTN_LAP, BTN_STOP, BTN_START, BTN_CLR};
  assign state   = st;

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a level only after DEB_CYCLES consecutive differing
  // samples; the press event is registered alongside the 0->1 acceptance
  always_ff @(posedge CLK) begin
    if (RST) begin
      stable <= '0;
      ev     <= '0;
      for (int i = 0; i < int'(NBTN); i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NBTN); i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
          ev[i]      <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Priority decode: only the highest-priority event of a cycle survives
  always_comb begin
    ev_clr   = ev[B_CLR];
    ev_stop  = ev[B_STOP] & ~ev[B_CLR];
    ev_start = ev[B_START] & ~ev[B_STOP] & ~ev[B_CLR];
    ev_lap   = ev[B_LAP] & ~ev[B_START] & ~ev[B_STOP] & ~ev[B_CLR];
  end

  // Run/pause/lap FSM with timebase divider and registered strobes/levels
  always_ff @(posedge CLK) begin
    if (RST) begin
      st        <= IDLE;
      div_cnt   <= '0;
      cnt_clr   <= 1'b0;
      cnt_inc   <= 1'b0;
      lap_load  <= 1'b0;
      disp_hold <= 1'b0;
      running   <= 1'b0;
    end else begin
      cnt_clr  <= 1'b0;
      cnt_inc  <= 1'b0;
      lap_load <= 1'b0;
      if (ev_clr) begin
        st        <= IDLE;
        div_cnt   <= '0;
        cnt_clr   <= 1'b1;
        disp_hold <= 1'b0;
        running   <= 1'b0;
      end else if (ev_stop) begin
        // divider holds so the fractional period survives the pause
        if (running) begin
          st        <= PAUSE;
          disp_hold <= 1'b0;
          running   <= 1'b0;
        end
      end else begin
        if (running) begin
          if (div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
            cnt_inc <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        if (ev_start) begin
          if (st == IDLE || st == PAUSE) begin
            st        <= RUN;
            running   <= 1'b1;
            disp_hold <= 1'b0;
          end
        end else if (ev_lap) begin
          case (st)
            RUN: begin
              st        <= LAP;
              lap_load  <= 1'b1;
              disp_hold <= 1'b1;
            end
            LAP: begin
              st        <= RUN;
              disp_hold <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a behavioural model pushes the expected output
// word every clock, a monitor pops and compares it half a cycle later, and
// each scenario task adds hand-derived checks at key edges.
module tb_stopwatch_ctrl;

  localparam int DIV = 10;
  localparam int DEB = 4;
  localparam int CLR = 0, START = 1, STOP = 2, LAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       cnt_clr, cnt_inc, lap_load, disp_hold, running;
  logic [1:0] state;

  int vectors    = 0;
  int miscompares = 0;

  stopwatch_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .CLK      (clk),
    .RST      (rst),
    .BTN_CLR  (btn[CLR]),
    .BTN_START(btn[START]),
    .BTN_STOP (btn[STOP]),
    .BTN_LAP  (btn[LAP]),
    .cnt_clr  (cnt_clr),
    .cnt_inc  (cnt_inc),
    .lap_load (lap_load),
    .disp_hold(disp_hold),
    .running  (running),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Expected word layout: {cnt_clr, cnt_inc, lap_load, disp_hold, running, state[1:0]}
  logic [6:0] sb [$];

  // Reference model state
  bit [3:0] m_s1, m_s2, m_stable, m_ev, ev_new;
  int       m_deb [4];
  int       m_div, m_st;
  bit       m_clr, m_inc, m_lap;

  task automatic model_step();
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_ev = 0;
      for (int b = 0; b < 4; b++) m_deb[b] = 0;
      m_div = 0; m_st = 0; m_clr = 0; m_inc = 0; m_lap = 0;
    end else begin
      ev_new = 0;
      for (int b = 0; b < 4; b++) begin
        if (m_s2[b] != m_stable[b]) begin
          if (m_deb[b] == DEB - 1) begin
            m_stable[b] = m_s2[b];
            m_deb[b] = 0;
            ev_new[b] = m_s2[b];
          end else m_deb[b]++;
        end else m_deb[b] = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn;
      m_clr = 0; m_inc = 0; m_lap = 0;
      if (m_ev[CLR]) begin
        m_st = 0; m_div = 0; m_clr = 1;
      end else if (m_ev[STOP]) begin
        if (m_st == 1 || m_st == 3) m_st = 2;
      end else begin
        if (m_st == 1 || m_st == 3) begin
          m_div++;
          if (m_div == DIV) begin m_div = 0; m_inc = 1; end
        end
        if (m_ev[START]) begin
          if (m_st == 0 || m_st == 2) m_st = 1;
        end else if (m_ev[LAP]) begin
          if (m_st == 1) begin m_st = 3; m_lap = 1; end
          else if (m_st == 3) m_st = 1;
        end
      end
      m_ev = ev_new;
    end
    sb.push_back({m_clr, m_inc, m_lap, (m_st == 3), (m_st == 1 || m_st == 3), 2'(m_st)});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Scoreboard monitor: compare on the falling edge, away from updates
  logic [6:0] exp_w, got_w;
  initial forever begin
    @(negedge clk);
    if (sb.size() != 0) begin
      exp_w = sb.pop_front();
      got_w = {cnt_clr, cnt_inc, lap_load, disp_hold, running, state};
      vectors++;
      if (got_w !== exp_w) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got=%b exp=%b", $time, got_w, exp_w);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 4'b0000;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 4'b0000;
    tick(3);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state); end
    vectors++; if ({cnt_clr, cnt_inc, lap_load, disp_hold, running} !== 5'b0) begin
      miscompares++; $display("FAIL reset_outputs got=%b exp=00000", {cnt_clr, cnt_inc, lap_load, disp_hold, running});
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    btn[START] = 1'b1;
    tick(6);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL start_early state=%0d exp=0", state); end
    tick(1);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL start_run state=%0d exp=1", state); end
    vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL start_running got=%b exp=1", running); end
    tick(9);
    vectors++; if (cnt_inc !== 1'b0) begin miscompares++; $display("FAIL start_inc_early got=%b exp=0", cnt_inc); end
    tick(1);
    vectors++; if (cnt_inc !== 1'b1) begin miscompares++; $display("FAIL start_inc_first got=%b exp=1", cnt_inc); end
    tick(10);
    vectors++; if (cnt_inc !== 1'b1) begin miscompares++; $display("FAIL start_inc_second got=%b exp=1", cnt_inc); end
    btn[START] = 1'b0;
    tick(10);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL start_release state=%0d exp=1", state); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btn[START] = (i % 4) < 2;
      tick(1);
      vectors++; if ({state, cnt_clr, cnt_inc, lap_load} !== 5'b0) begin
        miscompares++; $display("FAIL bounce_idle cyc=%0d got=%b exp=00000", i, {state, cnt_clr, cnt_inc, lap_load});
      end
    end
    btn[START] = 1'b0;
    tick(10);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL bounce_final state=%0d exp=0", state); end
  endtask

  task automatic test_stop_fraction();
    do_reset();
    btn[START] = 1'b1;
    tick(7);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL frac_run state=%0d exp=1", state); end
    // STOP raised now takes effect 7 edges later, when the divider reads 6
    btn[START] = 1'b0;
    btn[STOP]  = 1'b1;
    tick(7);
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL frac_pause state=%0d exp=2", state); end
    vectors++; if (cnt_inc !== 1'b0) begin miscompares++; $display("FAIL frac_pause_inc got=%b exp=0", cnt_inc); end
    btn[STOP] = 1'b0;
    tick(8);
    btn[START] = 1'b1;
    tick(7);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL frac_resume state=%0d exp=1", state); end
    btn[START] = 1'b0;
    // held divider 6 climbs to 9 over three edges and wraps on the fourth
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      vectors++; if (cnt_inc !== 1'b0) begin miscompares++; $display("FAIL frac_wait k=%0d got=%b exp=0", k, cnt_inc); end
    end
    tick(1);
    vectors++; if (cnt_inc !== 1'b1) begin miscompares++; $display("FAIL frac_inc got=%b exp=1", cnt_inc); end
  endtask

  task automatic test_lap();
    int n_inc, n_lap;
    btn[LAP] = 1'b1;
    tick(7);
    vectors++; if ({state, lap_load, disp_hold, running} !== 5'b11111) begin
      miscompares++; $display("FAIL lap_enter got=%b exp=11111", {state, lap_load, disp_hold, running});
    end
    btn[LAP] = 1'b0;
    n_inc = 0; n_lap = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      n_inc += int'(cnt_inc);
      n_lap += int'(lap_load);
    end
    vectors++; if (n_inc != 3) begin miscompares++; $display("FAIL lap_inc_count got=%0d exp=3", n_inc); end
    vectors++; if (n_lap != 0) begin miscompares++; $display("FAIL lap_load_count got=%0d exp=0", n_lap); end
    vectors++; if (disp_hold !== 1'b1) begin miscompares++; $display("FAIL lap_hold got=%b exp=1", disp_hold); end
    btn[LAP] = 1'b1;
    n_lap = 0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      n_lap += int'(lap_load);
    end
    vectors++; if ({state, disp_hold, running} !== 4'b0101) begin
      miscompares++; $display("FAIL lap_exit got=%b exp=0101", {state, disp_hold, running});
    end
    vectors++; if (n_lap != 0) begin miscompares++; $display("FAIL lap_exit_load got=%0d exp=0", n_lap); end
    btn[LAP] = 1'b0;
    tick(8);
  endtask

  task automatic test_clr_combo();
    btn[LAP] = 1'b1;
    tick(7);
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL combo_lap state=%0d exp=3", state); end
    btn[LAP] = 1'b0;
    tick(8);
    btn = 4'b0111;
    tick(7);
    vectors++; if ({state, cnt_clr, cnt_inc, lap_load, disp_hold, running} !== 7'b0010000) begin
      miscompares++; $display("FAIL combo_clr got=%b exp=0010000", {state, cnt_clr, cnt_inc, lap_load, disp_hold, running});
    end
    tick(1);
    vectors++; if (cnt_clr !== 1'b0) begin miscompares++; $display("FAIL combo_clr_width got=%b exp=0", cnt_clr); end
    btn = 4'b0000;
    tick(8);
    // divider must restart from zero: first increment a full period after RUN
    btn[START] = 1'b1;
    tick(7);
    btn[START] = 1'b0;
    tick(9);
    vectors++; if (cnt_inc !== 1'b0) begin miscompares++; $display("FAIL combo_div_early got=%b exp=0", cnt_inc); end
    tick(1);
    vectors++; if (cnt_inc !== 1'b1) begin miscompares++; $display("FAIL combo_div_zero got=%b exp=1", cnt_inc); end
  endtask

  task automatic test_stop_at_wrap();
    // RUN entered 10 edges ago; STOP raised 3 edges later lands on divider 9
    tick(3);
    btn[STOP] = 1'b1;
    tick(7);
    vectors++; if ({state, cnt_inc} !== 3'b100) begin
      miscompares++; $display("FAIL wrap_stop got=%b exp=100", {state, cnt_inc});
    end
    btn[STOP] = 1'b0;
    tick(8);
    btn[START] = 1'b1;
    tick(7);
    vectors++; if ({state, cnt_inc} !== 3'b010) begin
      miscompares++; $display("FAIL wrap_resume got=%b exp=010", {state, cnt_inc});
    end
    btn[START] = 1'b0;
    tick(1);
    vectors++; if (cnt_inc !== 1'b1) begin miscompares++; $display("FAIL wrap_first_inc got=%b exp=1", cnt_inc); end
  endtask

  task automatic test_rst_mid();
    btn[CLR] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    vectors++; if ({state, cnt_clr, cnt_inc, lap_load, disp_hold, running} !== 7'b0) begin
      miscompares++; $display("FAIL rst_mid got=%b exp=0000000", {state, cnt_clr, cnt_inc, lap_load, disp_hold, running});
    end
    rst = 1'b0;
    // the held CLR is re-debounced from scratch after reset
    tick(6);
    vectors++; if (cnt_clr !== 1'b0) begin miscompares++; $display("FAIL rst_redeb_early got=%b exp=0", cnt_clr); end
    tick(1);
    vectors++; if (cnt_clr !== 1'b1) begin miscompares++; $display("FAIL rst_redeb got=%b exp=1", cnt_clr); end
    btn[CLR] = 1'b0;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_stop_fraction();
    test_lap();
    test_clr_combo();
    test_stop_at_wrap();
    test_rst_mid();
    #10;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
